wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_arb_pkg.sv | 27 ++
 rtl/wb_arb_timeout.sv | 27 ++
 rtl/wb_master_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_master_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states,
// master index constants and the one-hot grant codes driven on gnt_o.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M0 = 2'd1,
    ST_OWN_M1 = 2'd2
  } arb_state_t;

  localparam logic M0_IDX = 1'b0;
  localparam logic M1_IDX = 1'b1;

  localparam logic [1:0] GNT_IDLE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // One-hot grant code for a state
  function automatic logic [1:0] state_gnt(input arb_state_t st);
    case (st)
      ST_OWN_M0: state_gnt = GNT_M0;
      ST_OWN_M1: state_gnt = GNT_M1;
      default:   state_gnt = GNT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the arbiter: counts consecutive stalled owner cycles
// and flags the cycle in which the count reaches TIMEOUT_CYCLES.
// Only built when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [15:0] P_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  // The current stalled cycle is the TIMEOUT_CYCLES-th one
  assign o_hit = i_run && !i_clr && (r_cnt == P_LAST);

  // Count stalled cycles; restart on ack, ownership loss or abort
  always_ff @(posedge clk) begin
    if (rst || i_clr || o_hit) r_cnt <= '0;
    else if (i_run)            r_cnt <= r_cnt + 16'd1;
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master (M0 data bus, M1 instruction bus) Wishbone arbiter onto one
// slave port. Round-robin on ties, re-arbitration only from IDLE.
// Optional stall timeout: define WB_ARB_TIMEOUT_EN to build it.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_data_i,
  output logic [1:0]  gnt_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_master_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_t r_state;
  logic       r_last_gnt;
  logic       w_own0, w_own1, w_hit;

  // Ownership is masked while rst is high so outputs drop immediately
  assign w_own0 = (r_state == ST_OWN_M0) && !rst;
  assign w_own1 = (r_state == ST_OWN_M1) && !rst;

`ifdef WB_ARB_TIMEOUT_EN
  logic w_run, w_clr;
  assign w_run = ((w_own0 && m0_stb_i) || (w_own1 && m1_stb_i)) && !s_ack_i;
  assign w_clr = !(w_own0 || w_own1) || s_ack_i;

  wb_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_run (w_run),
    .i_clr (w_clr),
    .o_hit (w_hit)
  );
`else
  assign w_hit = 1'b0;
`endif

  // Arbitration FSM: grant from IDLE, release one cycle after owner drops cyc
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= M1_IDX;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (r_last_gnt == M1_IDX) begin
              r_state    <= ST_OWN_M0;
              r_last_gnt <= M0_IDX;
            end else begin
              r_state    <= ST_OWN_M1;
              r_last_gnt <= M1_IDX;
            end
          end else if (m0_cyc_i) begin
            r_state    <= ST_OWN_M0;
            r_last_gnt <= M0_IDX;
          end else if (m1_cyc_i) begin
            r_state    <= ST_OWN_M1;
            r_last_gnt <= M1_IDX;
          end
        end
        ST_OWN_M0: if (!m0_cyc_i || w_hit) r_state <= ST_IDLE;
        ST_OWN_M1: if (!m1_cyc_i || w_hit) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o = rst ? GNT_IDLE : state_gnt(r_state);

  // Slave port follows the owner only; cyc/stb dropped on the abort cycle
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_data_o = '0;
    if (w_own0) begin
      s_cyc_o  = m0_cyc_i && !w_hit;
      s_stb_o  = m0_stb_i && !w_hit;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
    end else if (w_own1) begin
      s_cyc_o  = m1_cyc_i && !w_hit;
      s_stb_o  = m1_stb_i && !w_hit;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
    end
  end

  assign m0_ack_o  = w_own0 && s_ack_i;
  assign m1_ack_o  = w_own1 && s_ack_i;
  assign m0_data_o = w_own0 ? s_data_i : '0;
  assign m1_data_o = w_own1 ? s_data_i : '0;
  assign m0_err_o  = w_own0 && w_hit;
  assign m1_err_o  = w_own1 && w_hit;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter; timeout scenario enabled by
// WB_ARB_TIMEOUT_EN (TIMEOUT_CYCLES fixed at 8 here).
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_addr_i, m0_data_i;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_data_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i, m1_data_i;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_data_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o;
  logic        s_ack_i;
  logic [31:0] s_data_i;
  logic [1:0]  gnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_data_o(m0_data_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_data_o(m1_data_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_ack_i(s_ack_i), .s_data_i(s_data_i), .gnt_o(gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle combinational outputs
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_addr_i = 0; m0_data_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_addr_i = 0; m1_data_i = 0;
    s_ack_i = 0; s_data_i = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0; #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_scyc", 32'(s_cyc_o), 0);
    chk("rst_acks", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 0);
    rst = 0; #1;

    // M1 read alone, slave acks on third granted cycle
    m1_cyc_i = 1; m1_stb_i = 1; m1_sel_i = 4'hF; m1_addr_i = 32'hBFC00000; #1;
    chk("m1rd_pre_gnt", 32'(gnt_o), 0);
    chk("m1rd_pre_scyc", 32'(s_cyc_o), 0);
    step();
    chk("m1rd_gnt", 32'(gnt_o), 32'h2);
    chk("m1rd_scyc", 32'(s_cyc_o), 1);
    chk("m1rd_addr", s_addr_o, 32'hBFC00000);
    step();
    chk("m1rd_wait_ack", 32'(m1_ack_o), 0);
    step();
    s_ack_i = 1; s_data_i = 32'h3C080001; #1;
    chk("m1rd_ack", 32'(m1_ack_o), 1);
    chk("m1rd_data", m1_data_o, 32'h3C080001);
    chk("m1rd_m0_ack", 32'(m0_ack_o), 0);
    chk("m1rd_m0_data", m0_data_o, 0);
    step();
    s_ack_i = 0; s_data_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #1;
    chk("m1rd_release_gnt", 32'(gnt_o), 32'h2);
    chk("m1rd_release_scyc", 32'(s_cyc_o), 0);
    step();
    chk("m1rd_idle", 32'(gnt_o), 0);

    // Tie right after reset: M0 first, one IDLE cycle, then M1
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    chk("tie_first", 32'(gnt_o), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    chk("tie_gap_idle", 32'(gnt_o), 0);
    chk("tie_gap_scyc", 32'(s_cyc_o), 0);
    step();
    chk("tie_second", 32'(gnt_o), 32'h2);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();

    // Four back-to-back ties alternate M0, M1, M0, M1
    for (int r = 0; r < 4; r++) begin
      m0_cyc_i = 1; m1_cyc_i = 1;
      step();
      chk($sformatf("rr_round%0d", r), 32'(gnt_o), (r % 2 == 0) ? 32'h1 : 32'h2);
      m0_cyc_i = 0; m1_cyc_i = 0;
      step();
    end

    // M0 write while M1 toggles its inputs
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'b0011;
    m0_addr_i = 32'h80001000; m0_data_i = 32'hDEADBEEF;
    step();
    chk("m0wr_gnt", 32'(gnt_o), 32'h1);
    for (int t = 0; t < 3; t++) begin
      m1_cyc_i = t[0]; m1_stb_i = t[0]; m1_we_i = ~t[0];
      m1_sel_i = t[0] ? 4'hF : 4'h4;
      m1_addr_i = 32'hFFFF0000 + 32'(t); m1_data_i = 32'h12345678 ^ 32'(t);
      #1;
      chk($sformatf("m0wr_addr%0d", t), s_addr_o, 32'h80001000);
      chk($sformatf("m0wr_data%0d", t), s_data_o, 32'hDEADBEEF);
      chk($sformatf("m0wr_ctl%0d", t), 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'b1110011);
    end
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    s_ack_i = 1; #1;
    chk("m0wr_ack", 32'(m0_ack_o), 1);
    chk("m0wr_m1_ack", 32'(m1_ack_o), 0);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    step();
    chk("m0wr_idle", 32'(gnt_o), 0);

    // Reset during an M1 transaction drops it silently
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h00000040;
    step();
    chk("rstmid_gnt", 32'(gnt_o), 32'h2);
    rst = 1; s_ack_i = 1; s_data_i = 32'hCAFEF00D; #1;
    chk("rstmid_during_ack", 32'(m1_ack_o), 0);
    chk("rstmid_during_scyc", 32'(s_cyc_o), 0);
    step();
    chk("rstmid_gnt_after", 32'(gnt_o), 0);
    chk("rstmid_outs", 32'({s_cyc_o, s_stb_o, m1_ack_o, m1_err_o}), 0);
    chk("rstmid_m1data", m1_data_o, 0);
    chk("rstmid_saddr", s_addr_o, 0);
    idle_inputs();
    rst = 0;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: err on 8th stalled cycle, then M1 served
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    chk("tmo_gnt", 32'(gnt_o), 32'h1);
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("tmo_noerr%0d", c), 32'({m0_err_o, s_cyc_o}), 32'b01);
      step();
    end
    chk("tmo_err", 32'(m0_err_o), 1);
    chk("tmo_m1_err", 32'(m1_err_o), 0);
    chk("tmo_forced", 32'({s_cyc_o, s_stb_o}), 0);
    step();
    chk("tmo_idle", 32'(gnt_o), 0);
    chk("tmo_err_pulse", 32'(m0_err_o), 0);
    step();
    chk("tmo_other", 32'(gnt_o), 32'h2);
    s_ack_i = 1; s_data_i = 32'h0000BEEF; #1;
    chk("tmo_other_ack", 32'(m1_ack_o), 1);
    chk("tmo_other_data", m1_data_o, 32'h0000BEEF);
    idle_inputs();
    step(); step();
`else
    // No watchdog: a long stall keeps ownership and never raises err
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int c = 0; c < 12; c++) step();
    chk("nostall_gnt", 32'(gnt_o), 32'h1);
    chk("nostall_err", 32'({m0_err_o, m1_err_o}), 0);
    chk("nostall_scyc", 32'(s_cyc_o), 1);
    idle_inputs();
    step(); step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog");
  end

endmodule
